// File: rtl/alu_multicycle.sv
// Purpose : NZCV ALU with start/done handshake; AND/OR/ADD/SUB/pass-B in one step, iterative shift-add MUL and optional restoring UDIV.
// Latency : 1 cycle for single-cycle opcodes, N+1 cycles for MUL/UDIV (result written N edges after acceptance, done one cycle later).
// Backpr. : ready low while an iterative op runs; start is sampled only when ready=1 and is silently dropped otherwise (no queueing).
//
// Ports   : clk, reset (sync, active-high) | start, ALUcontrol[3:0], a[N-1:0], b[N-1:0] captured on acceptance
//           ready (idle), done (1-cycle pulse), result[N-1:0], zero, negative, carry, overflow (all registered)
// Config  : define ALU_DIV_EN to build the divider; otherwise opcode 1001 is treated as an unknown opcode.

module alu_multicycle #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   ALUcontrol,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         negative,
    output logic         carry,
    output logic         overflow
);

    localparam int CW = $clog2(N);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASB = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_UDIV = 4'b1001;
`endif

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // x: multiplier (shifts right) or dividend/quotient (shifts left)
    // y: multiplicand (shifts left) or divisor (static)
    // acc: partial product or partial remainder
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  y_q, y_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  result_q, result_d;
    logic          zero_q, zero_d;
    logic          neg_q, neg_d;
    logic          carry_q, carry_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
`ifdef ALU_DIV_EN
    logic          is_div_q, is_div_d;
`endif

    // ------------------------------------------------------------------
    // Single-cycle datapath, operating directly on the live inputs
    // ------------------------------------------------------------------
    logic [N:0]   sum_w;
    logic [N:0]   dif_w;
    logic [N-1:0] alu_res;
    logic         alu_c;
    logic         alu_v;
    logic         is_multi;

    assign sum_w = {1'b0, a} + {1'b0, b};
    assign dif_w = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res = '1;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUcontrol)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD: begin
                alu_res = sum_w[N-1:0];
                alu_c   = sum_w[N];
                alu_v   = (a[N-1] == b[N-1]) && (sum_w[N-1] != a[N-1]);
            end
            OP_SUB: begin
                alu_res = dif_w[N-1:0];
                // top bit of the widened difference is the borrow
                alu_c   = ~dif_w[N];
                alu_v   = (a[N-1] != b[N-1]) && (dif_w[N-1] != a[N-1]);
            end
            OP_PASB: alu_res = b;
            default: alu_res = '1;
        endcase
    end

`ifdef ALU_DIV_EN
    assign is_multi = (ALUcontrol == OP_MUL) || (ALUcontrol == OP_UDIV);
`else
    assign is_multi = (ALUcontrol == OP_MUL);
`endif

    // ------------------------------------------------------------------
    // One iteration of the shift-add multiplier / restoring divider
    // ------------------------------------------------------------------
    logic [N-1:0] x_step;
    logic [N-1:0] y_step;
    logic [N-1:0] acc_step;
    logic [N-1:0] fin_res;

`ifdef ALU_DIV_EN
    // Remainder stays below the divisor, so the shifted remainder fits in
    // N+1 bits and the difference's top bit is a clean borrow indicator.
    // A zero divisor never borrows, which yields an all-ones quotient.
    logic [N:0] rem_sh;
    logic [N:0] rem_dif;

    assign rem_sh  = {acc_q, x_q[N-1]};
    assign rem_dif = rem_sh - {1'b0, y_q};
`endif

    always_comb begin
        x_step   = x_q >> 1;
        y_step   = y_q << 1;
        acc_step = x_q[0] ? (acc_q + y_q) : acc_q;
`ifdef ALU_DIV_EN
        if (is_div_q) begin
            x_step   = {x_q[N-2:0], ~rem_dif[N]};
            y_step   = y_q;
            acc_step = rem_dif[N] ? rem_sh[N-1:0] : rem_dif[N-1:0];
        end
`endif
    end

`ifdef ALU_DIV_EN
    assign fin_res = is_div_q ? x_step : acc_step;
`else
    assign fin_res = acc_step;
`endif

    // ------------------------------------------------------------------
    // FSM: next-state and register updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
`ifdef ALU_DIV_EN
        is_div_d = is_div_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_multi) begin
                        state_d = S_RUN;
                        cnt_d   = CW'(N - 1);
                        acc_d   = '0;
`ifdef ALU_DIV_EN
                        is_div_d = (ALUcontrol == OP_UDIV);
                        x_d      = (ALUcontrol == OP_UDIV) ? a : b;
                        y_d      = (ALUcontrol == OP_UDIV) ? b : a;
`else
                        x_d      = b;
                        y_d      = a;
`endif
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        neg_d    = alu_res[N-1];
                        carry_d  = alu_c;
                        ovf_d    = alu_v;
                        done_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                x_d   = x_step;
                y_d   = y_step;
                acc_d = acc_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    // last iteration: write its outcome straight to result
                    state_d  = S_IDLE;
                    result_d = fin_res;
                    zero_d   = (fin_res == '0);
                    neg_d    = fin_res[N-1];
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
`ifdef ALU_DIV_EN
            is_div_q <= is_div_d;
`endif
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign negative = neg_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised multi-cycle successor to the datapath ALU, with a start/done handshake for the execute stage. It performs the existing single-cycle operations: AND, OR, ADD, SUB and pass-B. It adds an iterative unsigned multiply (shift-add) and an optional unsigned divide (restoring), both taking N cycles. Every result is registered together with NZCV flags, so the processor controller can stall on `ready` while a long operation runs.

## Interface
- `N`, 64: operand/result width in bits, ≥ 4.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only when `ready` is 1.
- `ALUcontrol`  input  4  operation code, captured with `start`.
- `a`  input  N  operand A, captured with `start`.
- `b`  input  N  operand B, captured with `start`.
- `ready`  output  1  high when the block is idle and can accept `start`.
- `done`  output  1  one-cycle pulse: `result` and flags were updated at the preceding edge.
- `result`  output  N  registered result; holds until the next operation completes.
- `zero`  output  1  registered; set when `result` is 0.
- `negative`  output  1  registered; copy of `result[N-1]`.
- `carry`  output  1  registered carry or no-borrow flag.
- `overflow`  output  1  registered signed-overflow flag.

## Operation
- Opcodes:
  - 0000: a & b
  - 0001: a | b
  - 0010: a + b
  - 0110: a − b
  - 0111: b
  - 1000: MUL, low N bits of a·b, unsigned
  - 1001: UDIV, quotient of a / b, unsigned
  - any other code: all ones (`'1`)
- States:
  - IDLE: `ready` = 1.
  - RUN: iterative MUL or UDIV in progress; `ready` = 0.
- Transitions:
  - IDLE with `start` and a single-cycle opcode: compute and register result and flags; stay in IDLE.
  - IDLE with `start` and MUL/UDIV: latch operands, load iteration counter with N−1, go to RUN.
  - RUN: one iteration per cycle. When the counter is 0, write result and flags and return to IDLE.
- `start` while in RUN is ignored: no queueing, no error.
- `start` in the same cycle that `done` is high is accepted, because the state is already IDLE.
- Operands and opcode are captured at acceptance. Later changes on `a`, `b` or `ALUcontrol` have no effect on the running operation.
- Flags:
  - `zero` and `negative` are derived from the new result for every opcode.
  - ADD: `carry` = carry-out of bit N−1; `overflow` = signed overflow.
  - SUB: `carry` = 1 when a ≥ b unsigned (no borrow); `overflow` = signed overflow of a − b.
  - All other opcodes: `carry` = `overflow` = 0.
- MUL: product truncated to N bits; the high half is discarded and sets no flag.
- UDIV by zero: result is all ones and the remainder is discarded. This falls out of the restoring algorithm and is not a special case.

## Timing
- Reset values, effective at the first edge with `reset` high: state IDLE, `result` = 0, all four flags = 0, `done` = 0, `ready` = 1.
- `reset` during RUN aborts the operation. No `done` is produced, and `result` and the flags are cleared to 0.
- Single-cycle opcode accepted at edge k: `result` and flags are valid and `done` = 1 during cycle k+1.
- MUL/UDIV accepted at edge k:
  - `ready` = 0 during cycles k+1 … k+N.
  - The result is written at edge k+N.
  - `done` = 1 and `ready` = 1 during cycle k+N+1.
- Latency is therefore 1 cycle for single-cycle ops and N+1 cycles for MUL/UDIV.
- `done` is never high for two consecutive cycles unless two separate operations completed.
- `ready` is decoded from the state register only; it has no combinational path from `start`.

## Configuration
- `ALU_DIV_EN` defined: opcode 1001 runs the restoring divider as specified above.
- `ALU_DIV_EN` undefined:
  - The divider logic is removed.
  - Opcode 1001 behaves as an unknown opcode: single-cycle, result all ones, `carry` = `overflow` = 0, `negative` = 1, `zero` = 0.

## Test plan
- Reset in IDLE, then deassert → `ready` = 1, `done` = 0, `result` = 0, flags 0000.
- N=64, ADD with a = 0x7FFF_FFFF_FFFF_FFFF, b = 1 → one cycle later `done` = 1, `result` = 0x8000_0000_0000_0000, `negative` = 1, `overflow` = 1, `carry` = 0, `zero` = 0.
- SUB with a = b = 5 → `result` = 0, `zero` = 1, `carry` = 1. Then SUB with a = 3, b = 5 → `result` = 0xFFFF_FFFF_FFFF_FFFE, `carry` = 0, `negative` = 1.
- MUL with a = 0x1_0000_0000, b = 0x1_0000_0003 → `ready` low for 64 cycles; `done` = 1 in cycle 65 with `result` = 0x3_0000_0000. A `start` pulse during RUN is ignored.
- With `ALU_DIV_EN`: UDIV 100/7 → `result` = 14. UDIV 9/0 → all ones, `negative` = 1. Without `ALU_DIV_EN`: 100/7 → all ones after 1 cycle.
- Assert `reset` at cycle 10 of a MUL → no `done` pulse, `result` = 0, `ready` = 1. A new ADD 2+3 accepted immediately afterwards yields 5.
